// File: rtl/seq_mac_if.sv
// Operand/result handshake bundle for seq_mac_unit.
// The master side produces operands and consumes results; the slave side is the MAC unit.
interface seq_mac_if #(
    parameter int W     = 4,
    parameter int GUARD = 4
);
    localparam int ACCW = 2 * W + GUARD;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            acc_clr;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out;
    logic            ovf;

    modport master (
        output in_valid, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, out, ovf
    );

    modport slave (
        input  in_valid, a, b, acc_clr, out_ready,
        output in_ready, out_valid, out, ovf
    );
endinterface

// File: rtl/seq_mac_unit.sv
// Unsigned sequential multiply-accumulate unit.
// A shift-add multiplier retires one multiplier bit per clock; the final bit is
// folded in combinationally on the last BUSY edge so the accumulator update and
// result presentation happen exactly W edges after the operands are accepted.
module seq_mac_unit #(
    parameter int W     = 4,
    parameter int GUARD = 4,
    parameter int SAT   = 0
) (
    input  logic clk,
    input  logic reset,
    seq_mac_if.slave bus
);
    localparam int ACCW = 2 * W + GUARD;
    localparam int PW   = 2 * W;
    localparam int CW   = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clr_q, clr_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            ovf_q, ovf_d;

    // Datapath helpers: current partial product step and the accumulate of the finished product.
    logic [PW-1:0]   addend;
    logic [PW-1:0]   prod_next;
    logic            last_bit;
    logic [ACCW-1:0] base;
    logic [ACCW:0]   sum;
    logic [ACCW-1:0] acc_new;
    logic            ovf_new;

    // Shift-add step and accumulator arithmetic for the current cycle.
    always_comb begin
        addend    = mplier_q[0] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0;
        prod_next = prod_q + addend;
        last_bit  = (cnt_q == CW'(W - 1));
        base      = clr_q ? '0 : acc_q;
        sum       = {1'b0, base} + {{(ACCW + 1 - PW){1'b0}}, prod_next};
        if (sum[ACCW]) begin
            acc_new = (SAT != 0) ? {ACCW{1'b1}} : sum[ACCW-1:0];
        end else begin
            acc_new = sum[ACCW-1:0];
        end
        // A clearing accept starts a fresh overflow history.
        ovf_new   = (clr_q ? 1'b0 : ovf_q) | sum[ACCW];
    end

    // Next-state and register-update decisions for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        clr_d    = clr_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    clr_d    = bus.acc_clr;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                prod_d   = prod_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    acc_d   = acc_new;
                    ovf_d   = ovf_new;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            clr_q    <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            clr_q    <= clr_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // The accumulator only changes on completion, so it doubles as the result register.
    assign bus.in_ready  = (state_q == IDLE) && reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = acc_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_mac_unit.sv
// Testbench for seq_mac_unit: three instances (wrap/GUARD=4, saturate/GUARD=0,
// wrap/GUARD=0) driven by directed and random operand streams, with expected
// results queued per instance and checked by an independent monitor.
module tb_seq_mac_unit;
    localparam int W = 4;

    typedef struct {
        int out;
        int ovf;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    logic [2:0]  iv;
    logic [2:0]  ic;
    logic [2:0]  ordy;
    logic [3:0]  ia[3];
    logic [3:0]  ib[3];
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  ovfw;
    logic [11:0] outv[3];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[3][$];
    int   macc[3];
    int   movf[3];
    int   accw[3];
    int   sat[3];

    seq_mac_if #(.W(W), .GUARD(4)) bus0 ();
    seq_mac_if #(.W(W), .GUARD(0)) bus1 ();
    seq_mac_if #(.W(W), .GUARD(0)) bus2 ();

    seq_mac_unit #(.W(W), .GUARD(4), .SAT(0)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    seq_mac_unit #(.W(W), .GUARD(0), .SAT(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
    seq_mac_unit #(.W(W), .GUARD(0), .SAT(0)) dut2 (.clk(clk), .reset(rst_n), .bus(bus2));

    assign bus0.in_valid = iv[0];
    assign bus0.a = ia[0];
    assign bus0.b = ib[0];
    assign bus0.acc_clr = ic[0];
    assign bus0.out_ready = ordy[0];
    assign bus1.in_valid = iv[1];
    assign bus1.a = ia[1];
    assign bus1.b = ib[1];
    assign bus1.acc_clr = ic[1];
    assign bus1.out_ready = ordy[1];
    assign bus2.in_valid = iv[2];
    assign bus2.a = ia[2];
    assign bus2.b = ib[2];
    assign bus2.acc_clr = ic[2];
    assign bus2.out_ready = ordy[2];

    assign ir   = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
    assign ov   = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign ovfw = {bus2.ovf, bus1.ovf, bus0.ovf};
    assign outv[0] = bus0.out;
    assign outv[1] = {4'b0000, bus1.out};
    assign outv[2] = {4'b0000, bus2.out};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference behaviour: exact product, optional clear, overflow wraps or pins at all-ones.
    task automatic model_mac(input int k, input int av, input int bv, input bit clr);
        int sum;
        int lim;
        lim = 1 << accw[k];
        sum = (clr ? 0 : macc[k]) + av * bv;
        if (clr) movf[k] = 0;
        if (sum >= lim) begin
            movf[k] = 1;
            sum = (sat[k] != 0) ? lim - 1 : sum - lim;
        end
        macc[k] = sum;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            macc[k] = 0;
            movf[k] = 0;
        end
    endtask

    task automatic issue(input int k, input int av, input int bv, input bit clr, input bit push);
        int   n;
        int   cn;
        exp_t e;
        @(negedge clk);
        ia[k] = 4'(av);
        ib[k] = 4'(bv);
        ic[k] = clr;
        iv[k] = 1'b1;
        n = 0;
        while (!ir[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) begin
            chk($sformatf("accept_timeout[%0d]", k), 0, 1);
            iv[k] = 1'b0;
            return;
        end
        cn = cyc;
        if (push) begin
            model_mac(k, av, bv, clr);
            e.out = macc[k];
            e.ovf = movf[k];
            e.cyc = cn + 1 + W;
            q[k].push_back(e);
        end
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ir != 3'b111 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ir != 3'b111) chk("idle_timeout", int'(ir), 7);
    endtask

    initial begin
        bit [2:0]    pv;
        exp_t        e;
        logic [11:0] snap;
        int          n;

        accw[0] = 12; accw[1] = 8; accw[2] = 8;
        sat[0]  = 0;  sat[1]  = 1; sat[2]  = 0;
        model_reset();
        rst_n = 1'b0;
        iv = '0;
        ic = '0;
        ordy = 3'b111;
        for (int k = 0; k < 3; k++) begin
            ia[k] = '0;
            ib[k] = '0;
        end
        pv = '0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        if (ov[k] && !pv[k]) begin
                            if (q[k].size() == 0) begin
                                chk($sformatf("unexpected_result[%0d]", k), int'(outv[k]), -1);
                            end else begin
                                e = q[k].pop_front();
                                chk($sformatf("out[%0d]", k), int'(outv[k]), e.out);
                                chk($sformatf("ovf[%0d]", k), int'(ovfw[k]), e.ovf);
                                chk($sformatf("latency_cycle[%0d]", k), cyc, e.cyc);
                            end
                        end
                    end
                    pv = ov;
                end
            end
            begin : watchdog
                repeat (20000) @(posedge clk);
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "watchdog expired");
            end
            begin : stimulus
                // Reset state while reset is held low.
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("rst_in_ready[%0d]", k), int'(ir[k]), 0);
                    chk($sformatf("rst_out_valid[%0d]", k), int'(ov[k]), 0);
                    chk($sformatf("rst_out[%0d]", k), int'(outv[k]), 0);
                    chk($sformatf("rst_ovf[%0d]", k), int'(ovfw[k]), 0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("in_ready_after_reset", int'(ir), 7);

                // Running sum of a*10 for a = 1..9.
                for (int i = 1; i <= 9; i++) issue(0, i, 10, i == 1, 1'b1);
                // Saturating and wrapping overflow, sticky flag, clear.
                issue(1, 15, 15, 1'b1, 1'b1);
                issue(2, 15, 15, 1'b1, 1'b1);
                issue(1, 15, 15, 1'b0, 1'b1);
                issue(2, 15, 15, 1'b0, 1'b1);
                issue(1, 2, 3, 1'b1, 1'b1);
                issue(2, 1, 1, 1'b0, 1'b1);
                // Zero operands.
                issue(0, 0, 15, 1'b0, 1'b1);
                issue(0, 15, 0, 1'b0, 1'b1);
                wait_idle();

                // Backpressure: result held, new operands ignored.
                ordy[0] = 1'b0;
                issue(0, 5, 6, 1'b0, 1'b1);
                n = 0;
                while (!ov[0] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_out_valid_seen", int'(ov[0]), 1);
                snap = outv[0];
                for (int i = 0; i < 5; i++) begin
                    ia[0] = 4'($urandom_range(1, 15));
                    ib[0] = 4'($urandom_range(1, 15));
                    iv[0] = 1'b1;
                    @(negedge clk);
                    chk("bp_out_valid", int'(ov[0]), 1);
                    chk("bp_in_ready", int'(ir[0]), 0);
                    chk("bp_out_stable", int'(outv[0]), int'(snap));
                end
                iv[0] = 1'b0;
                ordy[0] = 1'b1;
                @(posedge clk);
                #1;
                chk("bp_release_out_valid", int'(ov[0]), 0);
                chk("bp_release_in_ready", int'(ir[0]), 1);
                chk("bp_release_out_kept", int'(outv[0]), int'(snap));
                wait_idle();

                // Reset mid-operation aborts without a result.
                issue(0, 7, 9, 1'b0, 1'b0);
                @(posedge clk);
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("abort_out", int'(outv[0]), 0);
                chk("abort_out_valid", int'(ov[0]), 0);
                chk("abort_in_ready", int'(ir[0]), 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                issue(0, 3, 5, 1'b0, 1'b1);

                // Random traffic across all three configurations.
                for (int i = 0; i < 60; i++) begin
                    issue($urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 15),
                          ($urandom_range(0, 7) == 0), 1'b1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                wait_idle();
                @(negedge clk);
                for (int k = 0; k < 3; k++) chk($sformatf("pending_results[%0d]", k), q[k].size(), 0);
            end
        join_any

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
